// File: rtl/lock_pkg.sv
// Shared types and constants for the parametrised code lock.
package lock_pkg;
  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CHECK   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } lock_state_t;

  localparam logic [2:0] RGB_BLUE  = 3'b001;
  localparam logic [2:0] RGB_GREEN = 3'b010;
  localparam logic [2:0] RGB_RED   = 3'b100;
endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: one registered pulse once the raw input has been high for
// DEBOUNCE_CYC consecutive cycles, re-armed only after the input goes low.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic gen_rst,
  input  logic raw,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_CYC);

  logic [CW-1:0] cnt_r;
  logic          fired_r;

  // Stability counter saturates at TARGET; fired_r blocks repeat pulses while held.
  always_ff @(posedge clk or posedge gen_rst) begin
    if (gen_rst) begin
      cnt_r   <= '0;
      fired_r <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      pulse <= (cnt_r == TARGET) && !fired_r;
      if (!raw) begin
        cnt_r   <= '0;
        fired_r <= 1'b0;
      end else begin
        if (cnt_r != TARGET) cnt_r <= cnt_r + CW'(1);
        else                 cnt_r <= cnt_r;
        if (cnt_r == TARGET) fired_r <= 1'b1;
        else                 fired_r <= fired_r;
      end
    end
  end
endmodule

// File: rtl/lock_core_param.sv
// Parametrised code lock: debounced digit/ok buttons, password check with
// timed lockout after repeated failures, and password re-programming while open.
module lock_core_param
  import lock_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int DIGIT_W      = 4,
  parameter int MAX_ERR      = 3,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LOCKOUT_CYC  = 100_000_000,
  parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_PW = '0
) (
  input  logic                              clk,
  input  logic                              gen_rst,
  input  logic                              btn_digit,
  input  logic                              btn_ok,
  input  logic [DIGIT_W-1:0]                sw,
  output logic                              lock_status,
  output logic [DIGITS*DIGIT_W-1:0]         entry_bus,
  output logic [DIGITS*DIGIT_W-1:0]         pw_bus,
  output logic [$clog2(DIGITS+1)-1:0]       digit_cnt,
  output logic [$clog2(MAX_ERR+1)-1:0]      error_count,
  output logic                              enb_inp,
  output logic                              lockout_active,
  output logic [2:0]                        rgb
);
  localparam int BUS_W = DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int ERR_W = $clog2(MAX_ERR + 1);
  localparam int TMR_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] DIGITS_C  = CNT_W'(DIGITS);
  localparam logic [ERR_W-1:0] MAX_ERR_C = ERR_W'(MAX_ERR);
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(LOCKOUT_CYC - 1);

  logic             dig_p;
  logic             ok_p;
  lock_state_t      state_r;
  logic [TMR_W-1:0] tmr_r;
  logic [BUS_W-1:0] entry_shift;
  logic [ERR_W-1:0] err_next;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_digit (
    .clk(clk), .gen_rst(gen_rst), .raw(btn_digit), .pulse(dig_p)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_ok (
    .clk(clk), .gen_rst(gen_rst), .raw(btn_ok), .pulse(ok_p)
  );

  // First digit entered drifts to the most significant position.
  assign entry_shift = {entry_bus[BUS_W-DIGIT_W-1:0], sw};
  assign err_next    = error_count + ERR_W'(1);
  assign enb_inp     = ((state_r == ENTRY) || (state_r == OPEN)) && (digit_cnt < DIGITS_C);

  // Lock FSM with its datapath; ok takes priority over a same-cycle digit.
  always_ff @(posedge clk or posedge gen_rst) begin
    if (gen_rst) begin
      state_r        <= ENTRY;
      tmr_r          <= '0;
      lock_status    <= 1'b1;
      entry_bus      <= '0;
      pw_bus         <= DEFAULT_PW;
      digit_cnt      <= '0;
      error_count    <= '0;
      lockout_active <= 1'b0;
      rgb            <= RGB_BLUE;
    end else begin
      case (state_r)
        ENTRY: begin
          if (ok_p) begin
            if (digit_cnt == DIGITS_C) begin
              state_r <= CHECK;
            end else begin
              entry_bus <= '0;
              digit_cnt <= '0;
            end
          end else if (dig_p && (digit_cnt < DIGITS_C)) begin
            entry_bus <= entry_shift;
            digit_cnt <= digit_cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          entry_bus <= '0;
          digit_cnt <= '0;
          if (entry_bus == pw_bus) begin
            state_r     <= OPEN;
            error_count <= '0;
            lock_status <= 1'b0;
            rgb         <= RGB_GREEN;
          end else begin
            error_count <= err_next;
            if (err_next == MAX_ERR_C) begin
              state_r        <= LOCKOUT;
              tmr_r          <= TMR_LOAD;
              lockout_active <= 1'b1;
              rgb            <= RGB_RED;
            end else begin
              state_r <= ENTRY;
            end
          end
        end
        OPEN: begin
          if (ok_p) begin
            entry_bus <= '0;
            digit_cnt <= '0;
            if (digit_cnt == DIGITS_C) begin
              pw_bus      <= entry_bus;
              state_r     <= ENTRY;
              lock_status <= 1'b1;
              rgb         <= RGB_BLUE;
            end else if (digit_cnt == CNT_W'(0)) begin
              state_r     <= ENTRY;
              lock_status <= 1'b1;
              rgb         <= RGB_BLUE;
            end
          end else if (dig_p && (digit_cnt < DIGITS_C)) begin
            entry_bus <= entry_shift;
            digit_cnt <= digit_cnt + CNT_W'(1);
          end
        end
        LOCKOUT: begin
          if (tmr_r == TMR_W'(0)) begin
            state_r        <= ENTRY;
            error_count    <= '0;
            lockout_active <= 1'b0;
            rgb            <= RGB_BLUE;
          end else begin
            tmr_r <= tmr_r - TMR_W'(1);
          end
        end
        default: begin
          state_r        <= ENTRY;
          lock_status    <= 1'b1;
          entry_bus      <= '0;
          digit_cnt      <= '0;
          lockout_active <= 1'b0;
          rgb            <= RGB_BLUE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lock_core_param.sv
// Randomised scoreboard bench for lock_core_param against a behavioural lock model.
module tb_lock_core_param;
  localparam int DIGITS  = 4;
  localparam int MAX_ERR = 3;
  localparam int DEB     = 4;
  localparam int LOCK    = 20;

  logic        clk = 1'b0;
  logic        gen_rst = 1'b0;
  logic        btn_digit = 1'b0;
  logic        btn_ok = 1'b0;
  logic [3:0]  sw = 4'h0;
  logic        lock_status;
  logic [15:0] entry_bus;
  logic [15:0] pw_bus;
  logic [2:0]  digit_cnt;
  logic [1:0]  error_count;
  logic        enb_inp;
  logic        lockout_active;
  logic [2:0]  rgb;

  lock_core_param #(
    .DIGITS(4), .DIGIT_W(4), .MAX_ERR(3), .DEBOUNCE_CYC(DEB),
    .LOCKOUT_CYC(LOCK), .DEFAULT_PW(16'h0000)
  ) dut (
    .clk(clk), .gen_rst(gen_rst), .btn_digit(btn_digit), .btn_ok(btn_ok), .sw(sw),
    .lock_status(lock_status), .entry_bus(entry_bus), .pw_bus(pw_bus),
    .digit_cnt(digit_cnt), .error_count(error_count), .enb_inp(enb_inp),
    .lockout_active(lockout_active), .rgb(rgb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        lock;
    logic [15:0] entry;
    logic [15:0] pw;
    logic [2:0]  cnt;
    logic [1:0]  err;
    logic        lo;
    logic [2:0]  rgb;
    logic        enb;
  } snap_t;

  snap_t expq[$];
  snap_t last_exp;
  snap_t prev_s;
  snap_t mon_cur;
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;

  // Behavioural model: the lock as a list of typed digits plus a few flags.
  int          m_digits[$];
  logic [15:0] m_pw;
  int          m_err;
  bit          m_locked;
  bit          m_lockout;

  function automatic logic [15:0] m_code();
    logic [15:0] e = 16'h0;
    foreach (m_digits[i]) e = (e << 4) | 16'(m_digits[i]);
    return e;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.lock  = m_locked;
    s.entry = m_code();
    s.pw    = m_pw;
    s.cnt   = 3'(m_digits.size());
    s.err   = 2'(m_err);
    s.lo    = m_lockout;
    s.rgb   = m_lockout ? 3'b100 : (m_locked ? 3'b001 : 3'b010);
    s.enb   = !m_lockout && (m_digits.size() < DIGITS);
    return s;
  endfunction

  function automatic void model_push();
    snap_t s = model_snap();
    if (s != last_exp) begin
      expq.push_back(s);
      last_exp = s;
    end
  endfunction

  function automatic void model_reset();
    m_digits.delete();
    m_pw      = 16'h0000;
    m_err     = 0;
    m_locked  = 1'b1;
    m_lockout = 1'b0;
    last_exp  = model_snap();
    prev_s    = last_exp;
  endfunction

  function automatic void model_digit(input logic [3:0] v);
    if (m_lockout) return;
    if (m_digits.size() < DIGITS) begin
      m_digits.push_back(int'(v));
      model_push();
    end
  endfunction

  function automatic void model_ok();
    int n;
    logic [15:0] code;
    if (m_lockout) return;
    n    = m_digits.size();
    code = m_code();
    m_digits.delete();
    if (!m_locked) begin
      if (n == DIGITS) m_pw = code;
      if (n == DIGITS || n == 0) m_locked = 1'b1;
    end else if (n == DIGITS) begin
      if (code == m_pw) begin
        m_locked = 1'b0;
        m_err    = 0;
      end else begin
        m_err++;
        if (m_err == MAX_ERR) begin
          // Lockout entry and its later expiry are both fully determined now.
          m_lockout = 1'b1;
          model_push();
          m_lockout = 1'b0;
          m_err     = 0;
          model_push();
          m_lockout = 1'b1;
          m_err     = MAX_ERR;
          return;
        end
      end
    end
    model_push();
  endfunction

  function automatic void model_lockout_end();
    m_lockout = 1'b0;
    m_err     = 0;
  endfunction

  function automatic snap_t dut_snap();
    return snap_t'({lock_status, entry_bus, pw_bus, digit_cnt, error_count,
                    lockout_active, rgb, enb_inp});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every change of the visible outputs must match the next expected snapshot.
  always @(negedge clk) begin
    if (mon_en && !gen_rst) begin
      mon_cur = dut_snap();
      if (mon_cur !== prev_s) begin
        prev_s = mon_cur;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change actual=%h required=none", mon_cur);
        end else begin
          chk("scoreboard", 64'(mon_cur), 64'(expq.pop_front()));
        end
      end
    end
  end

  int lo_cnt = 0;
  bit lo_red = 1'b1;
  // Lockout window length and colour.
  always @(negedge clk) begin
    if (gen_rst) begin
      lo_cnt = 0;
      lo_red = 1'b1;
    end else if (lockout_active) begin
      lo_cnt++;
      if (rgb !== 3'b100) lo_red = 1'b0;
    end else if (lo_cnt != 0) begin
      chk("lockout_len", 64'(lo_cnt), 64'(LOCK));
      chk("lockout_rgb", 64'(lo_red), 64'(1));
      lo_cnt = 0;
      lo_red = 1'b1;
    end
  end

  task automatic press(input bit dig, input bit ok, input int len, input logic [3:0] v);
    @(negedge clk);
    if (len >= DEB) begin
      if (ok)       model_ok();
      else if (dig) model_digit(v);
    end
    sw        = v;
    btn_digit = dig;
    btn_ok    = ok;
    repeat (len) @(negedge clk);
    btn_digit = 1'b0;
    btn_ok    = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 0; i < DIGITS; i++) press(1'b1, 1'b0, 5, code[15-4*i -: 4]);
    press(1'b0, 1'b1, 5, 4'h0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    mon_en = 1'b0;
    #3 gen_rst = 1'b1;
    #1;
    model_reset();
    expq.delete();
    chk(name, 64'(dut_snap()), 64'(model_snap()));
    chk({name, "_pw"}, 64'(pw_bus), 64'(16'h0000));
    repeat (2) @(negedge clk);
    gen_rst = 1'b0;
    mon_en  = 1'b1;
  endtask

  initial begin
    int old_n;
    int r;
    int n;
    logic [3:0]  v;
    logic [15:0] code;

    model_reset();
    #2 gen_rst = 1'b1;
    #1 chk("reset_state", 64'(dut_snap()), 64'(model_snap()));
    repeat (2) @(negedge clk);
    gen_rst = 1'b0;
    mon_en  = 1'b1;

    // Default password opens the lock.
    for (int i = 0; i < DIGITS; i++) press(1'b1, 1'b0, 5, 4'h0);
    chk("four_digits_cnt", 64'(digit_cnt), 64'(4));
    chk("four_digits_enb", 64'(enb_inp), 64'(0));
    press(1'b0, 1'b1, 5, 4'h0);
    chk("open_lock", 64'(lock_status), 64'(0));
    chk("open_rgb", 64'(rgb), 64'(3'b010));

    // Short glitch is ignored; long press lands one digit at a fixed latency.
    press(1'b1, 1'b0, 3, 4'h9);
    @(negedge clk);
    old_n = m_digits.size();
    model_digit(4'h7);
    sw        = 4'h7;
    btn_digit = 1'b1;
    repeat (5) @(negedge clk);
    chk("latency_early", 64'(digit_cnt), 64'(old_n));
    @(negedge clk);
    chk("latency_edge", 64'(digit_cnt), 64'(old_n + 1));
    repeat (4) @(negedge clk);
    btn_digit = 1'b0;
    repeat (8) @(negedge clk);
    chk("glitch_one_digit", 64'(entry_bus), 64'(16'h0007));

    press(1'b0, 1'b1, 5, 4'h0);
    enter_code(16'h1234);
    chk("pw_store", 64'(pw_bus), 64'(16'h1234));
    chk("pw_relock", 64'(lock_status), 64'(1));
    enter_code(16'h0000);
    chk("err_one", 64'(error_count), 64'(1));
    enter_code(16'h1234);
    chk("reopen", 64'(lock_status), 64'(0));
    press(1'b0, 1'b1, 5, 4'h0);

    // Three failures -> lockout; a digit during lockout is dropped.
    for (int k = 0; k < MAX_ERR; k++) enter_code(16'h1111);
    chk("lockout_err", 64'(error_count), 64'(3));
    press(1'b1, 1'b0, 5, 4'h3);
    chk("lockout_ignore", 64'(digit_cnt), 64'(0));
    repeat (25) @(negedge clk);
    model_lockout_end();
    chk("lockout_exit_err", 64'(error_count), 64'(0));

    // Same-cycle digit and ok: ok wins, nothing latched, no error.
    press(1'b1, 1'b0, 5, 4'h5);
    press(1'b1, 1'b0, 5, 4'h6);
    press(1'b1, 1'b1, 5, 4'h7);
    chk("simul_cnt", 64'(digit_cnt), 64'(0));
    chk("simul_err", 64'(error_count), 64'(0));

    for (int k = 0; k < MAX_ERR; k++) enter_code(16'h1111);
    repeat (5) @(negedge clk);
    do_reset("reset_mid_lockout");

    enter_code(16'h0000);
    enter_code(16'hABCD);
    chk("pw_store2", 64'(pw_bus), 64'(16'hABCD));
    do_reset("reset_after_pw");

    for (int it = 0; it < 50; it++) begin
      r = $urandom_range(0, 99);
      n = m_digits.size();
      if (r < 40) begin
        if ($urandom_range(0, 1) == 1 && n < DIGITS) v = m_pw[15-4*n -: 4];
        else v = 4'($urandom_range(0, 15));
        press(1'b1, 1'b0, $urandom_range(2, 7), v);
      end else if (r < 65) begin
        press(1'b0, 1'b1, $urandom_range(2, 7), 4'h0);
      end else if (r < 85) begin
        code = ($urandom_range(0, 1) == 1) ? m_pw : 16'($urandom);
        enter_code(code);
      end else begin
        press(1'b1, 1'b1, $urandom_range(3, 7), 4'($urandom_range(0, 15)));
      end
      if (m_lockout) begin
        repeat (25) @(negedge clk);
        model_lockout_end();
      end
    end

    repeat (20) @(negedge clk);
    chk("queue_drained", 64'(expq.size()), 64'(0));
    chk("final_state", 64'(dut_snap()), 64'(model_snap()));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
